// File: rtl/pipe_mem_wb_if.sv
// EX-stage inputs and WB-stage outputs of the MEM/WB back end, grouped as one bus.
interface pipe_mem_wb_if;
    logic        EXwreg;
    logic        EXm2reg;
    logic        EXwmem;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult;
    logic [31:0] EXdi;
    logic        WBwreg;
    logic        WBm2reg;
    logic [4:0]  WBwn;
    logic [31:0] WBaluResult;
    logic [31:0] WBmo;
    logic [31:0] WBdata;
    logic        WBmemErr;

    modport master (
        output EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi,
        input  WBwreg, WBm2reg, WBwn, WBaluResult, WBmo, WBdata, WBmemErr
    );
    modport slave (
        input  EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi,
        output WBwreg, WBm2reg, WBwn, WBaluResult, WBmo, WBdata, WBmemErr
    );
endinterface

// File: rtl/pipe_mem_wb.sv
// EX/MEM register, word data memory with alignment/range checking, MEM/WB register
// and the write-back mux feeding the register file.
module pipe_mem_wb #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          clrn,
    pipe_mem_wb_if.slave  bus
);
    logic              m_wreg, m_m2reg, m_wmem;
    logic [4:0]        m_wn;
    logic [31:0]       m_alu, m_di;
    logic [ADDR_W-1:0] idx;
    logic              err;
    logic [31:0]       mo;
    logic [31:0]       mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_wreg  <= 1'b0;
            m_m2reg <= 1'b0;
            m_wmem  <= 1'b0;
            m_wn    <= '0;
            m_alu   <= '0;
            m_di    <= '0;
        end else begin
            m_wreg  <= bus.EXwreg;
            m_m2reg <= bus.EXm2reg;
            m_wmem  <= bus.EXwmem;
            m_wn    <= bus.EXwn;
            m_alu   <= bus.EXaluResult;
            m_di    <= bus.EXdi;
        end
    end

    // Only memory ops can fault; misaligned or beyond-DEPTH addresses never touch mem.
    assign idx = m_alu[ADDR_W+1:2];
    assign err = (m_wmem | m_m2reg) &
                 ((m_alu[1:0] != 2'b00) | (m_alu[31:ADDR_W+2] != '0));
    assign mo  = (err || !m_m2reg) ? 32'h0 : mem[idx];

    always_ff @(posedge clk) begin
        if (clrn && m_wmem && !err)
            mem[idx] <= m_di;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.WBwreg      <= 1'b0;
            bus.WBm2reg     <= 1'b0;
            bus.WBwn        <= '0;
            bus.WBaluResult <= '0;
            bus.WBmo        <= '0;
            bus.WBmemErr    <= 1'b0;
        end else begin
            bus.WBwreg      <= m_wreg & ~(m_m2reg & err);
            bus.WBm2reg     <= m_m2reg;
            bus.WBwn        <= m_wn;
            bus.WBaluResult <= m_alu;
            bus.WBmo        <= mo;
            bus.WBmemErr    <= err;
        end
    end

    assign bus.WBdata = bus.WBm2reg ? bus.WBmo : bus.WBaluResult;
endmodule

// File: tb/tb_pipe_mem_wb.sv
// Table-driven scoreboard bench for pipe_mem_wb: vectors drive EX, expected WB popped two edges later.
module tb_pipe_mem_wb;
    logic clk;
    logic clrn;
    int   total = 0;
    int   bad   = 0;

    pipe_mem_wb_if bus ();

    pipe_mem_wb #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b1;
    always #50 clk = ~clk;

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [4:0]  wn;
        logic [31:0] alu, di;
        logic        e_wreg;
        logic [31:0] e_mo, e_data;
        logic        e_err;
    } vec_t;

    vec_t q[$];
    vec_t tbl[16];

    function automatic vec_t mk(input logic wreg, m2reg, wmem, input logic [4:0] wn,
                                input logic [31:0] alu, di, input logic e_wreg,
                                input logic [31:0] e_mo, e_data, input logic e_err);
        vec_t v;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.wn = wn; v.alu = alu; v.di = di;
        v.e_wreg = e_wreg; v.e_mo = e_mo; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.EXwreg = v.wreg; bus.EXm2reg = v.m2reg; bus.EXwmem = v.wmem;
        bus.EXwn = v.wn; bus.EXaluResult = v.alu; bus.EXdi = v.di;
    endtask

    task automatic check_vec(input vec_t v);
        chk("wreg",  {31'b0, bus.WBwreg},   {31'b0, v.e_wreg});
        chk("m2reg", {31'b0, bus.WBm2reg},  {31'b0, v.m2reg});
        chk("wn",    {27'b0, bus.WBwn},     {27'b0, v.wn});
        chk("alu",   bus.WBaluResult,       v.alu);
        chk("mo",    bus.WBmo,              v.e_mo);
        chk("data",  bus.WBdata,            v.e_data);
        chk("err",   {31'b0, bus.WBmemErr}, {31'b0, v.e_err});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wreg"},  {31'b0, bus.WBwreg},   32'h0);
        chk({tag, "_m2reg"}, {31'b0, bus.WBm2reg},  32'h0);
        chk({tag, "_wn"},    {27'b0, bus.WBwn},     32'h0);
        chk({tag, "_alu"},   bus.WBaluResult,       32'h0);
        chk({tag, "_mo"},    bus.WBmo,              32'h0);
        chk({tag, "_data"},  bus.WBdata,            32'h0);
        chk({tag, "_err"},   {31'b0, bus.WBmemErr}, 32'h0);
    endtask

    // Sample the oldest in-flight vector (two edges old) before driving the next.
    task automatic tick(input vec_t v);
        @(negedge clk);
        if (q.size() == 2) check_vec(q.pop_front());
        drive(v);
        q.push_back(v);
    endtask

    task automatic drain();
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (q.size() > 0) begin
            @(negedge clk);
            if (q.size() == 2) check_vec(q.pop_front());
            drive(nop);
            if (q.size() == 1) begin
                @(negedge clk);
                check_vec(q.pop_front());
            end
        end
    endtask

    initial begin
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //          wreg m2r wmem wn  alu          di            e_wreg e_mo          e_data        e_err
        tbl[0]  = mk(1, 0, 0, 3, 32'h5,  32'h0,        1, 32'h0,        32'h5,        0);
        tbl[1]  = mk(0, 0, 1, 0, 32'h8,  32'hDEADBEEF, 0, 32'h0,        32'h8,        0);
        tbl[2]  = mk(1, 1, 0, 7, 32'h8,  32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        tbl[3]  = mk(0, 0, 1, 0, 32'h4,  32'h11111111, 0, 32'h0,        32'h4,        0);
        tbl[4]  = mk(0, 0, 1, 0, 32'h6,  32'h1234,     0, 32'h0,        32'h6,        1);
        tbl[5]  = mk(0, 0, 1, 0, 32'h84, 32'hFFFF,     0, 32'h0,        32'h84,       1);
        tbl[6]  = mk(1, 1, 0, 2, 32'h4,  32'h0,        1, 32'h11111111, 32'h11111111, 0);
        tbl[7]  = mk(1, 1, 0, 9, 32'h80, 32'h0,        0, 32'h0,        32'h0,        1);
        tbl[8]  = mk(0, 0, 1, 0, 32'h0,  32'hA0,       0, 32'h0,        32'h0,        0);
        tbl[9]  = mk(0, 0, 1, 0, 32'hC,  32'hC0C0,     0, 32'h0,        32'hC,        0);
        tbl[10] = mk(1, 1, 0, 1, 32'h0,  32'h0,        1, 32'hA0,       32'hA0,       0);
        tbl[11] = mk(1, 1, 0, 2, 32'h4,  32'h0,        1, 32'h11111111, 32'h11111111, 0);
        tbl[12] = mk(1, 1, 0, 3, 32'h8,  32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        tbl[13] = mk(1, 1, 0, 4, 32'hC,  32'h0,        1, 32'hC0C0,     32'hC0C0,     0);
        tbl[14] = mk(1, 0, 0, 31, 32'hFFFFFFFF, 32'h0, 1, 32'h0,        32'hFFFFFFFF, 0);
        tbl[15] = mk(1, 1, 0, 5, 32'h7C, 32'h0,        1, 32'h0,        32'h0,        0);

        drive(nop);
        clrn = 1'b0;
        #25 check_zero("reset");
        #25 clrn = 1'b1;

        // Seed the last word so the top-of-range load in tbl[15] reads a known zero.
        tick(mk(0, 0, 1, 0, 32'h7C, 32'h0, 0, 32'h0, 32'h7C, 0));
        for (int i = 0; i < 16; i++) tick(tbl[i]);
        drain();

        // Reset lands between the store's EX/MEM edge and its write edge.
        @(negedge clk);
        drive(mk(0, 0, 1, 0, 32'hC, 32'hAAAA, 0, 0, 0, 0));
        @(posedge clk);
        drive(nop);
        #10 clrn = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_low");
        @(posedge clk);
        #10 clrn = 1'b1;
        tick(mk(1, 1, 0, 4, 32'hC, 32'h0, 1, 32'hC0C0, 32'hC0C0, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_mem_wb.md
Name: pipe_mem_wb

Overview:
- Consumer end of the EX stage in the five-stage pipelined CPU.
- Takes the EX-stage outputs (EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi) and registers them into an EX/MEM register.
- Performs the word data-memory access and registers the results into a MEM/WB register.
- Presents write-back-ready values to the register file.

Parameters:
- DEPTH, 32, number of 32-bit words in data memory.
- ADDR_W, 5, word-address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clrn  input  1  reset, asynchronous, active-low.
- EXwreg  input  1  instruction writes the register file.
- EXm2reg  input  1  instruction is a load (write-back value comes from memory).
- EXwmem  input  1  instruction is a store.
- EXwn  input  5  destination register number.
- EXaluResult  input  32  ALU result; the byte address for loads and stores.
- EXdi  input  32  store data.
- WBwreg  output  1  registered write enable to the register file.
- WBm2reg  output  1  registered load flag.
- WBwn  output  5  registered destination register.
- WBaluResult  output  32  registered ALU result.
- WBmo  output  32  registered memory read data.
- WBdata  output  32  write-back value: WBmo when WBm2reg=1, else WBaluResult (combinational mux of registers).
- WBmemErr  output  1  registered memory-access error flag.

Behaviour:
- Reset:
  - clrn=0 immediately clears all EX/MEM and MEM/WB registers, so every WB* output goes to 0 (WBdata=0).
  - Data memory contents are not reset.
- Stage 1, EX/MEM: at posedge, the internal M regs latch all EX* inputs unchanged. There is no stall and no bubble input; a new instruction enters every cycle.
- Address decode in the MEM cycle:
  - Word index = M_alu[ADDR_W+1:2].
  - err = (M_wmem | M_m2reg) & ((M_alu[1:0] != 0) | (M_alu[31:ADDR_W+2] != 0)).
- Read:
  - mo = mem[index], combinational.
  - mo is forced to 0 when err=1 or M_m2reg=0.
- Write:
  - At the posedge ending the MEM cycle, mem[index] <= M_di if M_wmem=1, err=0 and clrn=1.
  - A store whose address is misaligned or out of range is suppressed.
- Stage 2, MEM/WB: on the same posedge:
  - WBwreg <= M_wreg & ~(M_m2reg & err).
  - WBm2reg, WBwn and WBaluResult latch the M values.
  - WBmo <= mo.
  - WBmemErr <= err.
- Latency:
  - An instruction presented on EX* before edge k appears on the WB* outputs after edge k+1 (two edges).
  - Throughput is one instruction per cycle.
- Store followed by a load to the same address:
  - The store writes at the edge where the load enters EX/MEM.
  - The load therefore reads the new value with no forwarding needed.
- A store carrying EXwreg=1 is passed through unchanged; decode guarantees this never happens.
- clrn asserted mid-operation:
  - A pending store in EX/MEM is discarded because M_wmem is cleared asynchronously.
  - No memory write occurs while clrn=0.
- Unknown (X) inputs are not sanitised; the bench drives known values.

Test Plan:
- Reset: clk toggles every 50 ns from clk=1; clrn=0 for 50 ns → all WB* = 0 and WBmemErr=0; release clrn.
- ALU pass-through: EXwreg=1, EXm2reg=0, EXwn=3, EXaluResult=32'h5 → two edges later WBwreg=1, WBwn=3, WBdata=32'h5, WBmo=0.
- Store then load, back-to-back:
  - Store: EXwmem=1, EXaluResult=32'h8, EXdi=32'hDEADBEEF.
  - Next cycle, load: EXm2reg=1, EXwreg=1, EXaluResult=32'h8, EXwn=7.
  - Required: the load gives WBwn=7, WBmo=WBdata=32'hDEADBEEF, WBmemErr=0.
- Misaligned and out-of-range accesses:
  - Store at 32'h6 with EXdi=32'h1234 → WBmemErr=1; a later load of 32'h4 returns the prior contents unchanged.
  - Load from 32'h80 (DEPTH=32) → WBmemErr=1, WBwreg=0, WBmo=0.
- Reset mid-store:
  - Store 32'hAAAA to 32'hC; drop clrn between the two edges; then release clrn.
  - A load of 32'hC returns the old value, and WB* are 0 while clrn=0.
- Streaming: loads from 32'h0, 32'h4, 32'h8 on consecutive cycles after seeding stores → one correct WBmo per cycle, in order.
